// File: rtl/noc_pe_adapter.sv
// -----------------------------------------------------------------------------
// noc_pe_adapter
//   Bridges a local processing element to one node of a 3x3 mesh NoC.
//   TX path: local requests {dest,data} are queued, then injected one flit per
//   cycle into the router as {V,dst,src,seq,payload} with a per-node sequence
//   number. RX path: flits leaving the router are filtered (idle / misrouted /
//   overflow) and matching ones are queued for the local consumer.
//
// Ports
//   clock, reset          single rising-edge clock, async active-low reset
//   enable                network-wide run enable (gates inject and sample)
//   tx_valid/tx_ready     local send handshake; tx_dest {row,col}, tx_data
//   noc_in                registered flit into the router
//   noc_out               flit from the router
//   rx_valid/rx_ready     local receive handshake; rx_src/rx_seq/rx_data = head
//   err_cnt               bad-destination requests (row/col 3 or self)
//   misroute_cnt          valid flits whose dst is not this node
//   drop_cnt              matching flits lost because the RX FIFO was full
// -----------------------------------------------------------------------------
module noc_pe_adapter #(
   parameter int ROW   = 0,
   parameter int COL   = 0,
   parameter int DEPTH = 4   // power of 2, >= 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic [3:0]  tx_dest,
   input  logic [15:0] tx_data,
   output logic [31:0] noc_in,
   input  logic [31:0] noc_out,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic [3:0]  rx_src,
   output logic [6:0]  rx_seq,
   output logic [15:0] rx_data,
   output logic [7:0]  err_cnt,
   output logic [7:0]  misroute_cnt,
   output logic [7:0]  drop_cnt
);
   localparam int          AW     = $clog2(DEPTH);
   localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
   localparam logic [1:0]  ROW_L  = 2'(ROW);
   localparam logic [1:0]  COL_L  = 2'(COL);
   localparam logic [3:0]  SELF   = {ROW_L, COL_L};

   // TX entries {dest,data}; RX entries {src,seq,payload}
   logic [19:0]   tx_mem_q [DEPTH];
   logic [19:0]   tx_mem_d [DEPTH];
   logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [AW:0]   tx_cnt_q, tx_cnt_d;
   logic [6:0]    tx_seq_q, tx_seq_d;
   logic [31:0]   noc_in_q, noc_in_d;

   logic [26:0]   rx_mem_q [DEPTH];
   logic [26:0]   rx_mem_d [DEPTH];
   logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [AW:0]   rx_cnt_q, rx_cnt_d;

   logic [7:0]    err_q, err_d, mis_q, mis_d, drop_q, drop_d;

   logic tx_full, tx_acc, tx_bad, tx_push, tx_pop;
   logic rx_full, rx_pop, in_v, in_match, rx_push, rx_drop;
   logic [19:0] tx_head;
   logic [26:0] rx_head;

   always_comb begin
      // ---------------- TX ----------------
      tx_full  = (tx_cnt_q == FULL);
      tx_ready = !tx_full;   // no credit for a same-cycle pop when full
      tx_acc   = tx_valid && !tx_full;
      tx_bad   = (tx_dest[3:2] == 2'd3) || (tx_dest[1:0] == 2'd3) || (tx_dest == SELF);
      tx_push  = tx_acc && !tx_bad;
      // pop decision uses registered occupancy, so a fresh push never bypasses
      tx_pop   = enable && (tx_cnt_q != '0);
      tx_head  = tx_mem_q[tx_rp_q];

      tx_mem_d = tx_mem_q;
      tx_wp_d  = tx_wp_q;
      tx_rp_d  = tx_rp_q;
      tx_cnt_d = tx_cnt_q;
      tx_seq_d = tx_seq_q;
      noc_in_d = '0;
      if (tx_push) begin
         tx_mem_d[tx_wp_q] = {tx_dest, tx_data};
         tx_wp_d           = tx_wp_q + 1'b1;
      end
      if (tx_pop) begin
         noc_in_d = {1'b1, tx_head[19:16], ROW_L, COL_L, tx_seq_q, tx_head[15:0]};
         tx_rp_d  = tx_rp_q + 1'b1;
         tx_seq_d = tx_seq_q + 1'b1;   // 7-bit wrap
      end
      if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;

      // ---------------- RX ----------------
      rx_full  = (rx_cnt_q == FULL);
      rx_valid = (rx_cnt_q != '0);
      rx_pop   = rx_valid && rx_ready;
      rx_head  = rx_mem_q[rx_rp_q];
      in_v     = enable && noc_out[31];
      in_match = (noc_out[30:27] == SELF);
      // a pop frees the slot in the same edge, so full+pop still accepts
      rx_push  = in_v && in_match && (!rx_full || rx_pop);
      rx_drop  = in_v && in_match && rx_full && !rx_pop;

      rx_mem_d = rx_mem_q;
      rx_wp_d  = rx_wp_q;
      rx_rp_d  = rx_rp_q;
      rx_cnt_d = rx_cnt_q;
      if (rx_push) begin
         rx_mem_d[rx_wp_q] = noc_out[26:0];
         rx_wp_d           = rx_wp_q + 1'b1;
      end
      if (rx_pop) rx_rp_d = rx_rp_q + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;

      // ---------------- saturating counters ----------------
      err_d  = err_q;
      mis_d  = mis_q;
      drop_d = drop_q;
      if (tx_acc && tx_bad && err_q != 8'hFF)     err_d  = err_q + 1'b1;
      if (in_v && !in_match && mis_q != 8'hFF)    mis_d  = mis_q + 1'b1;
      if (rx_drop && drop_q != 8'hFF)             drop_d = drop_q + 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            tx_mem_q[i] <= '0;
            rx_mem_q[i] <= '0;
         end
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
         tx_seq_q <= '0;
         noc_in_q <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
         err_q    <= '0;
         mis_q    <= '0;
         drop_q   <= '0;
      end else begin
         tx_mem_q <= tx_mem_d;
         tx_wp_q  <= tx_wp_d;
         tx_rp_q  <= tx_rp_d;
         tx_cnt_q <= tx_cnt_d;
         tx_seq_q <= tx_seq_d;
         noc_in_q <= noc_in_d;
         rx_mem_q <= rx_mem_d;
         rx_wp_q  <= rx_wp_d;
         rx_rp_q  <= rx_rp_d;
         rx_cnt_q <= rx_cnt_d;
         err_q    <= err_d;
         mis_q    <= mis_d;
         drop_q   <= drop_d;
      end
   end

   assign noc_in       = noc_in_q;
   assign rx_src       = rx_head[26:23];
   assign rx_seq       = rx_head[22:16];
   assign rx_data      = rx_head[15:0];
   assign err_cnt      = err_q;
   assign misroute_cnt = mis_q;
   assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_noc_pe_adapter.sv
// -----------------------------------------------------------------------------
// tb_noc_pe_adapter
//   Directed scenarios plus a randomized run for a node at (1,1), DEPTH=4.
//   A queue-based reference model predicts every output after each edge.
// -----------------------------------------------------------------------------
module tb_noc_pe_adapter;
   localparam int         ROW   = 1;
   localparam int         COL   = 1;
   localparam int         DEPTH = 4;
   localparam logic [3:0] SELF  = 4'b0101;

   logic        clock, reset, enable, tx_valid, tx_ready, rx_valid, rx_ready;
   logic [3:0]  tx_dest, rx_src;
   logic [15:0] tx_data, rx_data;
   logic [31:0] noc_in, noc_out;
   logic [6:0]  rx_seq;
   logic [7:0]  err_cnt, misroute_cnt, drop_cnt;

   noc_pe_adapter #(.ROW(ROW), .COL(COL), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest(tx_dest), .tx_data(tx_data),
      .noc_in(noc_in), .noc_out(noc_out),
      .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_src(rx_src), .rx_seq(rx_seq), .rx_data(rx_data),
      .err_cnt(err_cnt), .misroute_cnt(misroute_cnt), .drop_cnt(drop_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // ---------------- reference model ----------------
   logic [19:0] m_txq[$];   // {dest,data}
   logic [26:0] m_rxq[$];   // {src,seq,payload}
   logic [6:0]  m_seq;
   logic [31:0] m_noc_in;
   int          m_err, m_mis, m_drop;

   function automatic logic [31:0] mk(input logic [1:0] dr, input logic [1:0] dc,
                                      input logic [1:0] sr, input logic [1:0] sc,
                                      input logic [6:0] sq, input logic [15:0] d);
      return {1'b1, dr, dc, sr, sc, sq, d};
   endfunction

   task automatic model_reset();
      m_txq.delete();
      m_rxq.delete();
      m_seq    = '0;
      m_noc_in = '0;
      m_err    = 0;
      m_mis    = 0;
      m_drop   = 0;
   endtask

   // advance the model across one rising edge using the current inputs
   task automatic model_edge();
      bit          tx_rdy, rx_pop, rx_full, bad;
      logic [19:0] h;
      tx_rdy  = m_txq.size() < DEPTH;
      rx_pop  = (m_rxq.size() > 0) && rx_ready;
      rx_full = m_rxq.size() == DEPTH;
      if (enable && m_txq.size() > 0) begin
         h        = m_txq.pop_front();
         m_noc_in = {1'b1, h[19:16], 2'(ROW), 2'(COL), m_seq, h[15:0]};
         m_seq    = m_seq + 7'd1;
      end else begin
         m_noc_in = '0;
      end
      if (tx_valid && tx_rdy) begin
         bad = (tx_dest[3:2] == 2'd3) || (tx_dest[1:0] == 2'd3) || (tx_dest == SELF);
         if (bad) begin
            if (m_err < 255) m_err++;
         end else begin
            m_txq.push_back({tx_dest, tx_data});
         end
      end
      if (rx_pop) void'(m_rxq.pop_front());
      if (enable && noc_out[31]) begin
         if (noc_out[30:27] != SELF) begin
            if (m_mis < 255) m_mis++;
         end else if (!rx_full || rx_pop) begin
            m_rxq.push_back(noc_out[26:0]);
         end else begin
            if (m_drop < 255) m_drop++;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".noc_in"},   noc_in, m_noc_in);
      chk({tag, ".tx_ready"}, 32'(tx_ready), 32'(m_txq.size() < DEPTH));
      chk({tag, ".rx_valid"}, 32'(rx_valid), 32'(m_rxq.size() > 0));
      if (m_rxq.size() > 0)
         chk({tag, ".rx_head"}, 32'({rx_src, rx_seq, rx_data}), 32'(m_rxq[0]));
      chk({tag, ".err_cnt"},  32'(err_cnt),      32'(m_err));
      chk({tag, ".mis_cnt"},  32'(misroute_cnt), 32'(m_mis));
      chk({tag, ".drop_cnt"}, 32'(drop_cnt),     32'(m_drop));
   endtask

   task automatic cycle(input string tag);
      model_edge();
      @(posedge clock);
      #1;
      check_all(tag);
   endtask

   task automatic idle_inputs();
      tx_valid = 1'b0;
      tx_dest  = '0;
      tx_data  = '0;
      noc_out  = '0;
      rx_ready = 1'b0;
   endtask

   // reset takes effect between edges; released a couple of units after an edge
   task automatic do_reset(input string tag);
      reset = 1'b0;
      #1;
      model_reset();
      chk({tag, ".rst_noc_in"},   noc_in, 32'h0);
      chk({tag, ".rst_rx_valid"}, 32'(rx_valid), 32'h0);
      chk({tag, ".rst_tx_ready"}, 32'(tx_ready), 32'h1);
      check_all({tag, ".rst"});
      idle_inputs();
      @(posedge clock);
      #2;
      reset = 1'b1;
   endtask

   initial begin
      enable = 1'b0;
      idle_inputs();
      do_reset("init");

      // single injection, one-edge latency, sequence increments
      enable   = 1'b1;
      tx_valid = 1'b1; tx_dest = 4'b0010; tx_data = 16'hBEEF;
      cycle("inj_accept");
      chk("inj_not_yet", noc_in, 32'h0);
      tx_valid = 1'b0;
      cycle("inj_out");
      // dst (0,2), src (1,1), seq 0
      chk("inj_flit", noc_in, {1'b1, 2'd0, 2'd2, 2'd1, 2'd1, 7'd0, 16'hBEEF});
      tx_valid = 1'b1; tx_data = 16'h0001;
      cycle("inj2_accept");
      tx_valid = 1'b0;
      cycle("inj2_out");
      chk("inj2_seq", 32'(noc_in[22:16]), 32'd1);

      // fill TX while disabled, then drain
      do_reset("fill");
      enable   = 1'b0;
      tx_valid = 1'b1; tx_dest = 4'b1000;
      for (int i = 0; i < 5; i++) begin
         tx_data = 16'(16'hA000 + i);
         cycle("fill_push");
      end
      chk("fill_tx_ready", 32'(tx_ready), 32'h0);
      chk("fill_noc_idle", noc_in, 32'h0);
      tx_valid = 1'b0;
      enable   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle("drain");
         chk("drain_seq",  32'(noc_in[22:16]), 32'(i));
         chk("drain_data", 32'(noc_in[15:0]),  32'(16'hA000 + i));
      end
      cycle("drain_empty");
      chk("drain_idle", noc_in, 32'h0);

      // receive a matching flit, then a misrouted one
      do_reset("rx");
      enable  = 1'b1;
      noc_out = mk(2'd1, 2'd1, 2'd2, 2'd0, 7'd5, 16'h1234);
      cycle("rx_match");
      noc_out = '0;
      chk("rx_valid", 32'(rx_valid), 32'h1);
      chk("rx_src",   32'(rx_src),   32'h8);
      chk("rx_seq",   32'(rx_seq),   32'd5);
      chk("rx_data",  32'(rx_data),  32'h1234);
      cycle("rx_hold");
      chk("rx_hold_data", 32'(rx_data), 32'h1234);
      do_reset("mis");
      enable  = 1'b1;
      noc_out = mk(2'd0, 2'd2, 2'd2, 2'd0, 7'd5, 16'h1234);
      cycle("mis_in");
      noc_out = '0;
      cycle("mis_after");
      chk("mis_cnt",  32'(misroute_cnt), 32'd1);
      chk("mis_rx_v", 32'(rx_valid),     32'h0);

      // RX overflow, then full + simultaneous pop/push, then drain
      do_reset("ovf");
      enable   = 1'b1;
      rx_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         noc_out = mk(2'd1, 2'd1, 2'(i % 3), 2'd0, 7'(i), 16'(16'h0100 + i));
         cycle("ovf_in");
      end
      chk("ovf_drop", 32'(drop_cnt), 32'd2);
      rx_ready = 1'b1;
      noc_out  = mk(2'd1, 2'd1, 2'd0, 2'd2, 7'd9, 16'hCAFE);
      cycle("ovf_swap");
      chk("ovf_swap_drop", 32'(drop_cnt), 32'd2);
      noc_out  = '0;
      for (int i = 0; i < 4; i++) cycle("ovf_drain");
      chk("ovf_drained", 32'(rx_valid), 32'h0);
      cycle("ovf_empty_pop");
      rx_ready = 1'b0;

      // bad destinations and misroute saturation
      do_reset("bad");
      enable   = 1'b1;
      tx_valid = 1'b1; tx_dest = 4'b1100; tx_data = 16'h1111;
      cycle("bad_row3");
      tx_dest  = 4'b0101;
      cycle("bad_self");
      tx_valid = 1'b0;
      cycle("bad_idle");
      chk("bad_err",  32'(err_cnt), 32'd2);
      chk("bad_noc",  noc_in, 32'h0);
      noc_out = mk(2'd0, 2'd0, 2'd2, 2'd2, 7'd1, 16'h0);
      for (int i = 0; i < 300; i++) begin
         model_edge();
         @(posedge clock);
      end
      noc_out = '0;
      #1;
      check_all("sat");
      chk("sat_mis", 32'(misroute_cnt), 32'd255);

      // reset mid-burst
      do_reset("burst");
      enable   = 1'b1;
      tx_valid = 1'b1; tx_dest = 4'b0000; tx_data = 16'h7777;
      noc_out  = mk(2'd1, 2'd1, 2'd0, 2'd0, 7'd3, 16'h4444);
      cycle("burst1");
      cycle("burst2");
      chk("burst_live", 32'(noc_in[31]), 32'h1);
      #3;
      do_reset("mid");
      tx_valid = 1'b1; tx_dest = 4'b0000; tx_data = 16'h5555;
      cycle("post_accept");
      tx_valid = 1'b0;
      cycle("post_out");
      chk("post_seq",  32'(noc_in[22:16]), 32'd0);
      chk("post_data", 32'(noc_in[15:0]),  32'h5555);
      chk("post_rx",   32'(rx_valid),      32'h0);

      // randomized traffic
      do_reset("rand");
      for (int i = 0; i < 400; i++) begin
         enable   = ($urandom_range(0, 3) != 0);
         tx_valid = $urandom_range(0, 1) == 1;
         tx_dest  = 4'($urandom);
         tx_data  = 16'($urandom);
         rx_ready = ($urandom_range(0, 2) == 0);
         noc_out  = $urandom;
         if ($urandom_range(0, 9) < 7) noc_out[30:27] = SELF;
         cycle("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
